// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmitter that owns the fractional baud generator setup,
//            defers divisor changes to frame gaps and restarts its phase.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int          OVERSAMPLE  = 16,
    parameter int          STOP_BITS   = 1,
    parameter logic [15:0] DEF_DIVINT  = 16'd27,
    parameter logic [5:0]  DEF_DIVFRAC = 6'd8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cfg_we,
    input  logic [15:0] cfg_divint,
    input  logic [5:0]  cfg_divfrac,
    input  logic        cfg_parity_en,
    input  logic        cfg_parity_odd,
    output logic        cfg_pending,
    output logic [15:0] baud_divint,
    output logic [5:0]  baud_divfrac,
    output logic        gen_rstn,
    input  logic        baud_tick,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        txd,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [7:0] c_TICK_LAST = 8'(OVERSAMPLE - 1);
    localparam logic       c_STOP_LAST = 1'(STOP_BITS - 1);

    state_t      r_state_q,      w_state_d;
    logic [15:0] r_sh_divint_q,  w_sh_divint_d;
    logic [5:0]  r_sh_divfrac_q, w_sh_divfrac_d;
    logic        r_sh_par_en_q,  w_sh_par_en_d;
    logic        r_sh_par_odd_q, w_sh_par_odd_d;
    logic        r_pending_q,    w_pending_d;
    logic [15:0] r_divint_q,     w_divint_d;
    logic [5:0]  r_divfrac_q,    w_divfrac_d;
    logic        r_par_en_q,     w_par_en_d;
    logic        r_par_odd_q,    w_par_odd_d;
    logic [7:0]  r_shift_q,      w_shift_d;
    logic        r_par_bit_q,    w_par_bit_d;
    logic [7:0]  r_tick_cnt_q,   w_tick_cnt_d;
    logic [2:0]  r_bit_idx_q,    w_bit_idx_d;
    logic        r_stop_idx_q,   w_stop_idx_d;
    logic        r_txd_q,        w_txd_d;
    logic        r_tx_ready_q,   w_tx_ready_d;
    logic        r_busy_q,       w_busy_d;
    logic        r_gen_rstn_q,   w_gen_rstn_d;

    logic w_tick;
    logic w_bit_end;

    // Ticks only count while a frame is running and the generator is out of reset.
    assign w_tick    = baud_tick && r_gen_rstn_q &&
                       (r_state_q != S_IDLE) && (r_state_q != S_APPLY);
    assign w_bit_end = w_tick && (r_tick_cnt_q == c_TICK_LAST);

    always_comb begin
        w_state_d      = r_state_q;
        w_sh_divint_d  = r_sh_divint_q;
        w_sh_divfrac_d = r_sh_divfrac_q;
        w_sh_par_en_d  = r_sh_par_en_q;
        w_sh_par_odd_d = r_sh_par_odd_q;
        w_pending_d    = r_pending_q;
        w_divint_d     = r_divint_q;
        w_divfrac_d    = r_divfrac_q;
        w_par_en_d     = r_par_en_q;
        w_par_odd_d    = r_par_odd_q;
        w_shift_d      = r_shift_q;
        w_par_bit_d    = r_par_bit_q;
        w_tick_cnt_d   = r_tick_cnt_q;
        w_bit_idx_d    = r_bit_idx_q;
        w_stop_idx_d   = r_stop_idx_q;
        w_txd_d        = r_txd_q;

        if (cfg_we) begin
            w_sh_divint_d  = cfg_divint;
            w_sh_divfrac_d = cfg_divfrac;
            w_sh_par_en_d  = cfg_parity_en;
            w_sh_par_odd_d = cfg_parity_odd;
            w_pending_d    = 1'b1;
        end

        if (w_tick) begin
            w_tick_cnt_d = w_bit_end ? 8'd0 : r_tick_cnt_q + 8'd1;
        end

        case (r_state_q)
            S_IDLE: begin
                w_txd_d = 1'b1;
                if (r_pending_q) begin
                    w_state_d = S_APPLY;
                end else if (tx_valid && r_tx_ready_q) begin
                    w_state_d    = S_START;
                    w_shift_d    = tx_data;
                    w_par_bit_d  = (^tx_data) ^ r_par_odd_q;
                    w_tick_cnt_d = 8'd0;
                    w_txd_d      = 1'b0;
                end
            end
            S_APPLY: begin
                w_divint_d  = r_sh_divint_q;
                w_divfrac_d = r_sh_divfrac_q;
                w_par_en_d  = r_sh_par_en_q;
                w_par_odd_d = r_sh_par_odd_q;
                // A write landing in this cycle must survive for another pass.
                if (!cfg_we) begin
                    w_pending_d = 1'b0;
                end
                w_state_d = S_IDLE;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d   = S_DATA;
                    w_bit_idx_d = 3'd0;
                    w_txd_d     = r_shift_q[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx_q == 3'd7) begin
                        if (r_par_en_q) begin
                            w_state_d = S_PARITY;
                            w_txd_d   = r_par_bit_q;
                        end else begin
                            w_state_d    = S_STOP;
                            w_stop_idx_d = 1'b0;
                            w_txd_d      = 1'b1;
                        end
                    end else begin
                        w_bit_idx_d = r_bit_idx_q + 3'd1;
                        w_shift_d   = r_shift_q >> 1;
                        w_txd_d     = r_shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_d    = S_STOP;
                    w_stop_idx_d = 1'b0;
                    w_txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                w_txd_d = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_idx_q == c_STOP_LAST) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_stop_idx_d = r_stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_txd_d   = 1'b1;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        w_busy_d     = (w_state_d != S_IDLE);
        w_tx_ready_d = (w_state_d == S_IDLE) && !w_pending_d;
        w_gen_rstn_d = !((w_state_d == S_APPLY) ||
                         ((r_state_q == S_IDLE) && (w_state_d == S_START)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q      <= S_IDLE;
            r_sh_divint_q  <= DEF_DIVINT;
            r_sh_divfrac_q <= DEF_DIVFRAC;
            r_sh_par_en_q  <= 1'b0;
            r_sh_par_odd_q <= 1'b0;
            r_pending_q    <= 1'b0;
            r_divint_q     <= DEF_DIVINT;
            r_divfrac_q    <= DEF_DIVFRAC;
            r_par_en_q     <= 1'b0;
            r_par_odd_q    <= 1'b0;
            r_shift_q      <= 8'd0;
            r_par_bit_q    <= 1'b0;
            r_tick_cnt_q   <= 8'd0;
            r_bit_idx_q    <= 3'd0;
            r_stop_idx_q   <= 1'b0;
            r_txd_q        <= 1'b1;
            r_tx_ready_q   <= 1'b0;
            r_busy_q       <= 1'b0;
            r_gen_rstn_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_sh_divint_q  <= w_sh_divint_d;
            r_sh_divfrac_q <= w_sh_divfrac_d;
            r_sh_par_en_q  <= w_sh_par_en_d;
            r_sh_par_odd_q <= w_sh_par_odd_d;
            r_pending_q    <= w_pending_d;
            r_divint_q     <= w_divint_d;
            r_divfrac_q    <= w_divfrac_d;
            r_par_en_q     <= w_par_en_d;
            r_par_odd_q    <= w_par_odd_d;
            r_shift_q      <= w_shift_d;
            r_par_bit_q    <= w_par_bit_d;
            r_tick_cnt_q   <= w_tick_cnt_d;
            r_bit_idx_q    <= w_bit_idx_d;
            r_stop_idx_q   <= w_stop_idx_d;
            r_txd_q        <= w_txd_d;
            r_tx_ready_q   <= w_tx_ready_d;
            r_busy_q       <= w_busy_d;
            r_gen_rstn_q   <= w_gen_rstn_d;
        end
    end

    assign cfg_pending  = r_pending_q;
    assign baud_divint  = r_divint_q;
    assign baud_divfrac = r_divfrac_q;
    assign gen_rstn     = r_gen_rstn_q;
    assign tx_ready     = r_tx_ready_q;
    assign txd          = r_txd_q;
    assign busy         = r_busy_q;

endmodule
`default_nettype wire
